// File: rtl/dca_matrix_lsu_rdata_packer.sv
// Packs AXI R-channel beats into full tensor rows, one read burst per row,
// with a one-row skid buffer behind the output register.
module dca_matrix_lsu_rdata_packer #(
    parameter int BW_AXI_DATA   = 32,
    parameter int BW_TENSOR_ROW = 128,
    parameter int BW_NUM_ROW    = 8
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     clear,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [BW_NUM_ROW-1:0]    cmd_num_row,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [BW_AXI_DATA-1:0]   rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [BW_TENSOR_ROW-1:0] row_data,
    output logic                     row_last,
    output logic                     done,
    output logic                     busy,
    output logic                     error
);

    localparam int BEATS   = BW_TENSOR_ROW / BW_AXI_DATA;
    localparam int BW_BEAT = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW_BEAT-1:0]    LAST_BEAT = BW_BEAT'(BEATS - 1);
    localparam logic [BW_NUM_ROW-1:0] ONE_ROW   = BW_NUM_ROW'(1);

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } state_t;

    state_t                   state_q, state_d;
    logic [BW_NUM_ROW-1:0]    rows_left_q, rows_left_d;
    logic [BW_BEAT-1:0]       beat_cnt_q, beat_cnt_d;
    logic [BW_TENSOR_ROW-1:0] asm_q, asm_d;
    logic                     buf_full_q, buf_full_d;
    logic                     buf_last_q, buf_last_d;
    logic [BW_TENSOR_ROW-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    logic                     cmd_fire;
    logic                     beat_fire;
    logic                     row_fire;
    logic                     out_free;
    logic                     final_beat;
    logic                     last_row;
    logic [BW_TENSOR_ROW-1:0] assembled;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rready     = (state_q == ST_COLLECT) && !buf_full_q;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign beat_fire  = rvalid && rready;
    assign row_fire   = out_valid_q && row_ready;
    assign out_free   = !out_valid_q || row_ready;
    assign final_beat = (beat_cnt_q == LAST_BEAT);
    assign last_row   = (rows_left_q == ONE_ROW);

    // Current buffer contents with the incoming beat merged at its slot.
    always_comb begin
        assembled = asm_q;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt_q == BW_BEAT'(b)) begin
                assembled[b*BW_AXI_DATA +: BW_AXI_DATA] = rdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rows_left_d = rows_left_q;
        beat_cnt_d  = beat_cnt_q;
        asm_d       = asm_q;
        buf_full_d  = buf_full_q;
        buf_last_d  = buf_last_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        error_d     = error_q;
        done_d      = row_fire && out_last_q;

        if (row_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    rows_left_d = cmd_num_row;
                    beat_cnt_d  = '0;
                    if (cmd_num_row == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (beat_fire) begin
                    asm_d = assembled;
                    // rlast is only cross-checked; beat_cnt alone decides the row boundary.
                    if ((rresp != 2'b00) || (rlast != final_beat)) begin
                        error_d = 1'b1;
                    end
                    if (final_beat) begin
                        beat_cnt_d  = '0;
                        rows_left_d = rows_left_q - ONE_ROW;
                        if (last_row) begin
                            state_d = ST_IDLE;
                        end
                        if (out_free) begin
                            out_data_d  = assembled;
                            out_valid_d = 1'b1;
                            out_last_d  = last_row;
                        end else begin
                            buf_full_d = 1'b1;
                            buf_last_d = last_row;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW_BEAT'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // rready is low while the buffer is full, so this never races a final beat.
        if (buf_full_q && out_free) begin
            out_data_d  = asm_q;
            out_valid_d = 1'b1;
            out_last_d  = buf_last_q;
            buf_full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            state_q     <= ST_IDLE;
            rows_left_q <= '0;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            buf_full_q  <= 1'b0;
            buf_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_left_q <= rows_left_d;
            beat_cnt_q  <= beat_cnt_d;
            asm_q       <= asm_d;
            buf_full_q  <= buf_full_d;
            buf_last_q  <= buf_last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign row_valid = out_valid_q;
    assign row_data  = out_data_q;
    assign row_last  = out_last_q;
    assign done      = done_q;
    assign error     = error_q;
    assign busy      = (state_q != ST_IDLE) || buf_full_q || out_valid_q;

endmodule
